// File: rtl/ps2_typed_char_matcher_if.sv
// Controller-side bundle of the typed-character matcher: sequencer inputs and
// keystroke/match/score outputs. The master is the game controller, the slave is the matcher.
interface ps2_typed_char_matcher_if;
  logic       enable;
  logic       load_word;
  logic [7:0] num_char;
  logic [7:0] comparison_data;
  logic       key_valid;
  logic [7:0] key_code;
  logic       get_next_character;
  logic       mismatch;
  logic       word_done;
  logic [7:0] correct_count;
  logic [7:0] error_count;
  logic       frame_error;

  modport master (
    output enable, load_word, num_char, comparison_data,
    input  key_valid, key_code, get_next_character, mismatch,
           word_done, correct_count, error_count, frame_error
  );

  modport slave (
    input  enable, load_word, num_char, comparison_data,
    output key_valid, key_code, get_next_character, mismatch,
           word_done, correct_count, error_count, frame_error
  );
endinterface

// File: rtl/ps2_typed_char_matcher.sv
// PS/2 receiver, make-code filter and keystroke matcher for the typing game.
// Optional macro PS2_PARITY_CHECK_EN: reject frames whose parity bit is not odd.
module ps2_typed_char_matcher #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     ps2_clk,
  input  logic                     ps2_dat,
  ps2_typed_char_matcher_if.slave  mif
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [1:0]    clk_sync, dat_sync;
  logic          clk_filt, strobe, dat;
  logic [FW-1:0] filt_cnt;
  state_t        state, state_nxt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [TW-1:0] tmo_cnt;
  logic          frame_ok, frame_bad, stop_good;
  logic          brk_pend, ext_pend;
  logic          key_valid, get_next, mismatch, word_done, frame_error, load_d;
  logic [7:0]    key_code, correct_count, error_count;

  assign dat = dat_sync[1];

  // Synchronize both lines; the clock must hold a new level FILTER_LEN samples
  // before it counts, and only its falling transition yields a strobe.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_filt <= 1'b1;
      filt_cnt <= '0;
      strobe   <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
      strobe   <= 1'b0;
      if (clk_sync[1] == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_cnt <= '0;
        clk_filt <= clk_sync[1];
        strobe   <= ~clk_sync[1];
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  logic par_bit;
  assign stop_good = dat & (^{shreg, par_bit});
`else
  assign stop_good = dat;
`endif

  always_comb begin
    state_nxt = state;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    if (state != S_IDLE && tmo_cnt == TW'(TIMEOUT_CYCLES)) begin
      state_nxt = S_IDLE;
      frame_bad = 1'b1;
    end else if (strobe) begin
      case (state)
        S_IDLE:   if (!dat) state_nxt = S_DATA;
        S_DATA:   if (bit_cnt == 3'd7) state_nxt = S_PARITY;
        S_PARITY: state_nxt = S_STOP;
        S_STOP: begin
          state_nxt = S_IDLE;
          frame_ok  = stop_good;
          frame_bad = ~stop_good;
        end
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= S_IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      tmo_cnt     <= '0;
      brk_pend    <= 1'b0;
      ext_pend    <= 1'b0;
      key_valid   <= 1'b0;
      key_code    <= '0;
      frame_error <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_bit     <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      tmo_cnt     <= (strobe || state == S_IDLE) ? '0 : tmo_cnt + 1'b1;
      frame_error <= frame_bad;
      key_valid   <= 1'b0;
      if (strobe && state == S_IDLE) bit_cnt <= '0;
      if (strobe && state == S_DATA) begin
        shreg   <= {dat, shreg[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
`ifdef PS2_PARITY_CHECK_EN
      if (strobe && state == S_PARITY) par_bit <= dat;
`endif
      // Prefix bytes arm a flag; the byte after any prefix is swallowed.
      if (frame_ok) begin
        if (shreg == 8'hF0) begin
          brk_pend <= 1'b1;
        end else if (shreg == 8'hE0) begin
          ext_pend <= 1'b1;
        end else if (brk_pend || ext_pend) begin
          brk_pend <= 1'b0;
          ext_pend <= 1'b0;
        end else begin
          key_code  <= shreg;
          key_valid <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      get_next      <= 1'b0;
      mismatch      <= 1'b0;
      word_done     <= 1'b0;
      correct_count <= '0;
      error_count   <= '0;
      load_d        <= 1'b0;
    end else begin
      get_next <= 1'b0;
      mismatch <= 1'b0;
      load_d   <= mif.load_word;
      // A new word pre-empts any keystroke matched in the same cycle.
      if (mif.load_word) begin
        correct_count <= '0;
        word_done     <= 1'b0;
      end else begin
        if (key_valid && mif.enable && !word_done) begin
          if (key_code == mif.comparison_data) begin
            get_next      <= 1'b1;
            correct_count <= correct_count + 8'd1;
            if (correct_count + 8'd1 == mif.num_char) word_done <= 1'b1;
          end else begin
            mismatch <= 1'b1;
            if (error_count != 8'hFF) error_count <= error_count + 8'd1;
          end
        end
        if (load_d && mif.num_char == 8'd0) word_done <= 1'b1;
      end
    end
  end

  assign mif.key_valid          = key_valid;
  assign mif.key_code           = key_code;
  assign mif.get_next_character = get_next;
  assign mif.mismatch           = mismatch;
  assign mif.word_done          = word_done;
  assign mif.correct_count      = correct_count;
  assign mif.error_count        = error_count;
  assign mif.frame_error        = frame_error;
endmodule

// File: doc/ps2_typed_char_matcher.md
# ps2_typed_char_matcher

Receives the player's keystrokes from the PS/2 keyboard and compares them to the expected scan code presented by the word sequencer. It deserializes PS/2 device-to-host frames, drops break (F0-prefixed) and extended (E0-prefixed) codes, and checks each make code against `comparison_data`. On a match it pulses `get_next_character` to advance the sequencer. It also tracks word completion and error counts for the game controller.

## Interface
- `FILTER_LEN`, default 4: consecutive identical synchronized samples required before `ps2_clk` is treated as changed.
- `TIMEOUT_CYCLES`, default 50000: idle `clk` cycles inside a frame before the frame is abandoned.
- `clk`  in  1  system clock.
- `resetn`  in  1  reset: synchronous, active-low.
- `ps2_clk`  in  1  raw PS/2 clock, asynchronous.
- `ps2_dat`  in  1  raw PS/2 data, asynchronous.
- `enable`  in  1  matching enabled (game running).
- `load_word`  in  1  one-cycle pulse: new word loaded, restart progress.
- `num_char`  in  8  characters in the current word.
- `comparison_data`  in  8  expected make code for the current character.
- `key_valid`  out  1  one-cycle pulse: new make code on `key_code`.
- `key_code`  out  8  last accepted make code; held between pulses.
- `get_next_character`  out  1  one-cycle pulse on a correct keystroke.
- `mismatch`  out  1  one-cycle pulse on a wrong keystroke.
- `word_done`  out  1  level: all `num_char` characters typed correctly.
- `correct_count`  out  8  correct characters typed in the current word.
- `error_count`  out  8  wrong keystrokes since reset, saturating at 255.
- `frame_error`  out  1  one-cycle pulse when a frame is discarded.

## Operation
- **Input conditioning:** `ps2_clk` and `ps2_dat` each pass through a 2-FF synchronizer. The filtered clock changes only after `FILTER_LEN` equal samples. A falling edge of the filtered clock is a sample strobe; `ps2_dat` is sampled on the strobe.
- **Frame FSM** (one strobe per bit):
  - IDLE: data=0 goes to DATA; data=1 stays in IDLE with no error.
  - DATA: 8 bits, LSB first, shifted into `shreg`; after bit 7 goes to PARITY.
  - PARITY: captures the parity bit, goes to STOP.
  - STOP: stop=1 means the frame is good; stop=0 means `frame_error`. Either way returns to IDLE.
- **Frame timeout:** the timeout counter resets on every strobe. In any non-IDLE state, reaching `TIMEOUT_CYCLES` forces IDLE and pulses `frame_error`.
- **Code filter** (applied to good frames):
  - 0xF0 sets `brk_pend`.
  - 0xE0 sets `ext_pend`.
  - Any other code with either flag set is consumed silently and clears both flags.
  - Otherwise `key_code` is loaded with the code and `key_valid` pulses.
  - Auto-repeat make codes are accepted as separate keystrokes.
- **Match logic** on `key_valid`, when `enable=1` and `word_done=0`:
  - `key_code == comparison_data`: pulse `get_next_character` and increment `correct_count`. If the new count equals `num_char`, set `word_done`.
  - Otherwise: pulse `mismatch`; `error_count` increments and saturates at 255.
  - When `enable=0` or `word_done=1`, keys are decoded but never matched.
- **`load_word`** clears `correct_count` and `word_done`. `error_count` is cleared only by reset.
  - `num_char==0`: `word_done` sets on the cycle after `load_word`.
  - `load_word` coincident with a match event: `load_word` wins and the keystroke is discarded from matching (`key_valid` still pulses).
- **Reset:** all outputs are 0 and the FSM is in IDLE. `brk_pend`, `ext_pend`, filters and counters clear, and the filtered clock resets to 1. Reset mid-frame abandons the frame with no `frame_error`.

## Timing
- Stop-bit strobe to `key_valid`: 1 cycle.
- `key_valid` to `get_next_character`/`mismatch`: 1 cycle.
- `correct_count` and `word_done` update in the same cycle as `get_next_character`.
- `comparison_data` must be stable on the cycle `key_valid` is high. The sequencer updates it on the cycle after `get_next_character`.
- Consecutive match events are at least one full PS/2 frame apart (≥ ~500 µs), so there is no back-pressure.
- Raw `ps2_clk` falling edge to strobe: 2 + `FILTER_LEN` cycles.

## Configuration
- `PS2_PARITY_CHECK_EN`:
  - Defined: in STOP, a frame is good only if stop=1 and the parity bit makes odd parity over data+parity. Otherwise the frame is dropped, `frame_error` pulses, and filter flags are unchanged.
  - Undefined: the parity bit is captured and ignored; only start and stop are checked.

## Test plan
- **Correct word:** `load_word`, `num_char`=3, sequencer presenting 24, 21, 2B; send frames 24, 21, 2B. Expect three `get_next_character` pulses, `correct_count`=3, `word_done`=1, `error_count`=0.
- **Break filtering:** send 24, F0, 24 with expected 24. Expect exactly one `key_valid` (key_code=24) and one `get_next_character`. The released 24 produces nothing.
- **Wrong key:** expected 2A, send 1C. Expect `mismatch` pulse, `error_count`=1, no `get_next_character`, `correct_count` unchanged. Then send 2A and expect a match.
- **Extended prefix and timeout:** send E0, 75, then 1C. Only 1C yields `key_valid`. Stop `ps2_clk` after 4 data bits. Expect `frame_error` after `TIMEOUT_CYCLES` and that the next full frame decodes correctly.
- **Parity error:** send 0x24 with even parity. With `PS2_PARITY_CHECK_EN`: `frame_error` pulses and no `key_valid`. Without it: `key_valid` with key_code=24.
- **Gating and precedence:** with `enable=0`, a frame yields `key_valid` but no match pulses. `load_word` coincident with a match event leaves `correct_count`=0. `error_count` saturates at 255 after 256 wrong keys. Reset mid-frame returns all outputs to 0.
